// File: rtl/env_vca_pkg.sv
// Shared constants and state encoding for the envelope VCA stage.
// DEF_ENV_W is the envelope width also used by the ADSR generator.
package env_vca_pkg;

  localparam int DEF_SAMPLE_W = 8;
  localparam int DEF_ENV_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } vca_state_e;

endpackage

// File: rtl/env_vca_shift_add_mul.sv
// Serial signed-by-unsigned shift-add multiplier: one multiplicand bit per cycle, B_W cycles.
// p is the combinational next accumulator value, so it is the full product in the cycle done is high.
module shift_add_mul #(
  parameter int A_W = 8,
  parameter int B_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               done,
  output logic [A_W+B_W-1:0] p
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(B_W) + 1;

  logic [P_W-1:0]   acc_q, acc_d;
  logic [B_W-1:0]   b_sh_q, b_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [P_W-1:0]   a_ext;
  logic [P_W-1:0]   addend;
  logic             last;

  // a must stay stable for the whole run; the caller holds it in a register
  always_comb begin
    a_ext  = {{B_W{a[A_W-1]}}, a};
    addend = b_sh_q[0] ? (a_ext << cnt_q) : '0;
    last   = busy_q && (cnt_q == CNT_W'(B_W - 1));
    done   = last;
    p      = acc_q + addend;
  end

  always_comb begin
    acc_d  = acc_q;
    b_sh_d = b_sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      acc_d  = '0;
      b_sh_d = b;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d  = acc_q + addend;
      b_sh_d = b_sh_q >> 1;
      cnt_d  = cnt_q + 1'b1;
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      b_sh_q <= b_sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/env_vca.sv
// Envelope VCA: scales a signed sample by an unsigned envelope with a serial multiplier,
// valid/ready on both sides, and unity-gain bypass when the envelope is full scale.
module env_vca
  import env_vca_pkg::*;
#(
  parameter int DATA_W = DEF_SAMPLE_W,
  parameter int ENV_W  = DEF_ENV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sample,
  input  logic [ENV_W-1:0]  env,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sample
);

  vca_state_e state_q, state_d;

  logic [DATA_W-1:0]       sample_q, sample_d;
  logic                    full_scale_q, full_scale_d;
  logic [DATA_W-1:0]       out_sample_q, out_sample_d;
  logic                    accept;
  logic                    mul_done;
  logic [DATA_W+ENV_W-1:0] mul_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // in_ready only in IDLE, so a DONE-cycle consume never doubles as an accept
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    accept    = in_ready && in_valid;
  end

  always_comb begin
    sample_d     = sample_q;
    full_scale_d = full_scale_q;
    out_sample_d = out_sample_q;
    if (accept) begin
      sample_d     = in_sample;
      full_scale_d = &env;
    end
    if ((state_q == ST_MUL) && mul_done) begin
      out_sample_d = full_scale_q ? sample_q : mul_p[DATA_W+ENV_W-1:ENV_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q     <= '0;
      full_scale_q <= 1'b0;
      out_sample_q <= '0;
    end else begin
      sample_q     <= sample_d;
      full_scale_q <= full_scale_d;
      out_sample_q <= out_sample_d;
    end
  end

  assign out_sample = out_sample_q;

  shift_add_mul #(
    .A_W (DATA_W),
    .B_W (ENV_W)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .a     (sample_q),
    .b     (env),
    .done  (mul_done),
    .p     (mul_p)
  );

endmodule

// File: tb/tb_env_vca.sv
// Directed-vector and random-stream bench for env_vca: fixed 8-cycle latency, floor scaling,
// full-scale bypass, output backpressure and mid-operation reset.
module tb_env_vca;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sample;
  logic [7:0] env;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sample;

  int applied     = 0;
  int miscompares = 0;
  int exp_q[$];

  typedef struct {
    logic [7:0] sample;
    logic [7:0] env;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  env_vca dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .env        (env),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample)
  );

  function automatic int model(input logic [7:0] s, input logic [7:0] e);
    int si;
    int ei;
    si = $signed(s);
    ei = e;
    if (e == 8'hFF) return si;
    return (si * ei) >>> 8;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    applied++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Waits for in_ready, presents one sample, then scrambles the inputs and counts cycles to out_valid
  task automatic apply_stimulus(input logic [7:0] s, input logic [7:0] e, output int lat);
    for (int k = 0; k < 50 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    check_output("in_ready_before_accept", int'(in_ready), 1);
    in_valid  = 1'b1;
    in_sample = s;
    env       = e;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_sample = 8'($urandom);
    env       = 8'($urandom);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{8'd100,     8'h80, 8'd50};
    vecs[1]  = '{8'(-128),   8'h80, 8'(-64)};
    vecs[2]  = '{8'(-1),     8'h01, 8'(-1)};
    vecs[3]  = '{8'(-1),     8'h00, 8'd0};
    vecs[4]  = '{8'(-77),    8'hFF, 8'(-77)};
    vecs[5]  = '{8'd127,     8'hFE, 8'd126};
    vecs[6]  = '{8'd0,       8'hFF, 8'd0};
    vecs[7]  = '{8'd127,     8'hFF, 8'd127};
    vecs[8]  = '{8'(-128),   8'hFF, 8'(-128)};
    vecs[9]  = '{8'd127,     8'h01, 8'd0};
    vecs[10] = '{8'(-128),   8'h01, 8'(-1)};
    vecs[11] = '{8'(-128),   8'h7F, 8'(-64)};
    vecs[12] = '{8'd64,      8'h40, 8'd16};
    vecs[13] = '{8'(-100),   8'hC8, 8'(-79)};
    vecs[14] = '{8'd127,     8'h80, 8'd63};
    vecs[15] = '{8'(-128),   8'hFE, 8'(-127)};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_sample = 8'd0;
    env       = 8'd0;
    #1;
    check_output("reset_in_ready",   int'(in_ready),   1);
    check_output("reset_out_valid",  int'(out_valid),  0);
    check_output("reset_out_sample", int'(out_sample), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].sample, vecs[i].env, lat);
      check_output($sformatf("latency_v%0d", i), lat, 8);
      check_output($sformatf("sample_v%0d", i), $signed(out_sample), $signed(vecs[i].expected));
      @(posedge clk); #1;
      check_output($sformatf("consumed_v%0d", i), int'(out_valid), 0);
    end

    // Backpressure: DONE held 20 cycles with in_valid high and changing inputs
    out_ready = 1'b0;
    apply_stimulus(8'd50, 8'h80, lat);
    check_output("bp_latency", lat, 8);
    for (int k = 0; k < 20; k++) begin
      in_valid  = 1'b1;
      in_sample = 8'($urandom);
      env       = 8'($urandom);
      @(posedge clk); #1;
      check_output($sformatf("bp_hold_%0d", k), int'({out_valid, in_ready, out_sample}),
                   int'({1'b1, 1'b0, 8'd25}));
    end
    in_sample = 8'd10;
    env       = 8'h80;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_output("bp_release", int'({out_valid, in_ready}), int'(2'b01));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("bp_reaccept", int'(in_ready), 0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check_output("bp_next_latency", lat, 8);
    check_output("bp_next_sample", $signed(out_sample), 5);
    @(posedge clk); #1;

    // Reset during the fourth multiply cycle
    for (int k = 0; k < 50 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    in_valid  = 1'b1;
    in_sample = 8'd90;
    env       = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_output("rst_mid_out_valid",  int'(out_valid),  0);
    check_output("rst_mid_out_sample", int'(out_sample), 0);
    check_output("rst_mid_in_ready",   int'(in_ready),   1);
    #2 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_output("rst_no_output", seen, 0);
    check_output("rst_sample_zero", int'(out_sample), 0);

    // Random stream with random out_ready
    fork
      begin : driver
        logic [7:0] s;
        logic [7:0] e;
        logic       hs;
        int         g;
        int         r;
        for (int i = 0; i < 1000; i++) begin
          s = 8'($urandom);
          r = $urandom_range(0, 9);
          e = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          in_valid  = 1'b1;
          in_sample = s;
          env       = e;
          g  = 0;
          hs = 1'b0;
          do begin
            hs = in_ready;
            @(posedge clk); #1;
            g++;
          end while (!hs && g < 200);
          if (!hs) begin
            check_output("stream_accept_timeout", 0, 1);
            break;
          end
          exp_q.push_back(model(s, e));
        end
        in_valid = 1'b0;
      end
      begin : monitor
        int         got;
        int         cycles;
        logic       pv;
        logic       pr;
        logic [7:0] ps;
        got    = 0;
        cycles = 0;
        pv     = 1'b0;
        pr     = 1'b0;
        ps     = 8'd0;
        while (got < 1000 && cycles < 40000) begin
          @(posedge clk); #1;
          cycles++;
          if (pv && pr) begin
            if (exp_q.size() == 0) check_output("stream_duplicate", 1, 0);
            else check_output($sformatf("stream_%0d", got), $signed(ps), exp_q.pop_front());
            got++;
          end
          pv        = out_valid;
          ps        = out_sample;
          pr        = 1'($urandom_range(0, 1));
          out_ready = pr;
        end
        check_output("stream_count", got, 1000);
      end
    join
    check_output("stream_leftover", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
